// File: rtl/rpmp_link_pkg.sv
// Shared definitions for the host-side parallel link initiator.
// Holds the command codes, status bit positions, FSM states and per-command bus drive.
package rpmp_link_pkg;

  localparam logic [1:0] CMD_TEST   = 2'b00;
  localparam logic [1:0] CMD_STATUS = 2'b01;
  localparam logic [1:0] CMD_RDATA  = 2'b10;
  localparam logic [1:0] CMD_CTRL   = 2'b11;

  localparam int ST_RW    = 15;
  localparam int ST_IOMEM = 14;
  localparam int ST_RESET = 13;
  localparam int ST_ERROR = 12;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WAIT_ACK, S_STROBE, S_HOLD, S_WAIT_REL
  } state_t;

  typedef enum logic {SRC_REQ, SRC_EVT} src_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] data;
    src_t        src;
  } xact_t;

  // Byte-lane enables: [1]=r[15:8], [0]=r[7:0]
  function automatic logic [1:0] oe_for(input logic [1:0] op);
    case (op)
      CMD_RDATA: oe_for = 2'b01;
      CMD_CTRL:  oe_for = 2'b11;
      default:   oe_for = 2'b00;
    endcase
  endfunction

  function automatic logic [15:0] ro_for(input logic [1:0] op, input logic [15:0] data);
    case (op)
      CMD_RDATA: ro_for = {8'h00, data[7:0]};
      CMD_CTRL:  ro_for = data;
      default:   ro_for = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/rpmp_sync2.sv
// Two-flop synchroniser for the asynchronous cartridge handshake lines.
module rpmp_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/rpmp_host_link.sv
// Host initiator: serialises local requests into strobed link transactions and
// fetches the cartridge status word whenever atn falls.
module rpmp_host_link
  import rpmp_link_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned STROBE_CYC  = 3,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned ACK_TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        atn,
  input  logic        ack,
  output logic        ratn,
  output logic [1:0]  cmd,
  output logic [15:0] r_o,
  output logic [1:0]  r_oe,
  input  logic [15:0] r_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        evt_valid,
  output logic [15:0] evt_status,
  output logic        err,
  output logic        busy
);
  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);
  localparam logic [7:0] ACK_LAST    = 8'(ACK_TIMEOUT - 1);

  state_t      state, state_n;
  xact_t       xact;
  logic [7:0]  cnt;
  logic [15:0] sample;
  logic        tmo, pending, atn_s, ack_s, atn_q, atn_fall, ev;

  rpmp_sync2 #(.RST_VAL(1'b1)) u_sync_atn (.clk(clk), .reset(reset), .d(atn), .q(atn_s));
  rpmp_sync2 #(.RST_VAL(1'b0)) u_sync_ack (.clk(clk), .reset(reset), .d(ack), .q(ack_s));

  // A synchronised edge arriving while idle is taken directly, so it beats a same-cycle request.
  assign atn_fall  = atn_q & ~atn_s;
  assign ev        = pending | atn_fall;
  assign req_ready = (state == S_IDLE) & ~ev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (ev || req_valid) state_n = S_SETUP;
      S_SETUP:    if (cnt == SETUP_LAST) state_n = S_WAIT_ACK;
      S_WAIT_ACK: if (ack_s) state_n = S_STROBE;
                  else if (cnt == ACK_LAST) state_n = S_HOLD;
      S_STROBE:   if (cnt == STROBE_LAST) state_n = S_HOLD;
      S_HOLD:     if (cnt == HOLD_LAST) state_n = S_WAIT_REL;
      S_WAIT_REL: if (!ack_s || cnt == ACK_LAST) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    ratn = (state == S_WAIT_ACK) || (state == S_STROBE);
    cmd  = busy ? xact.op : 2'b00;
    r_o  = busy ? ro_for(xact.op, xact.data) : 16'h0000;
    r_oe = busy ? oe_for(xact.op) : 2'b00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      atn_q      <= 1'b1;
      pending    <= 1'b0;
      cnt        <= '0;
      tmo        <= 1'b0;
      xact       <= '0;
      sample     <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      evt_valid  <= 1'b0;
      evt_status <= '0;
      err        <= 1'b0;
    end else begin
      atn_q     <= atn_s;
      rsp_valid <= 1'b0;
      evt_valid <= 1'b0;
      err       <= 1'b0;
      pending   <= ev & (state != S_IDLE);
      cnt       <= (state == S_IDLE || state_n != state) ? 8'd0 : cnt + 8'd1;
      if (state == S_IDLE && state_n == S_SETUP) begin
        tmo  <= 1'b0;
        xact <= ev ? '{op: CMD_STATUS, data: 16'h0000, src: SRC_EVT}
                   : '{op: req_op, data: req_data, src: SRC_REQ};
      end
      if (state == S_WAIT_ACK && !ack_s && cnt == ACK_LAST) tmo <= 1'b1;
      if (state == S_STROBE && cnt == STROBE_LAST) sample <= r_i;
      if (state == S_WAIT_REL && state_n == S_IDLE) begin
        // ack still high here means the release wait ran out
        if (tmo || ack_s) err <= 1'b1;
        else if (xact.src == SRC_REQ) begin
          rsp_valid <= 1'b1;
          rsp_data  <= (xact.op == CMD_TEST || xact.op == CMD_STATUS) ? sample : 16'h0000;
        end else begin
          evt_valid  <= 1'b1;
          evt_status <= sample;
        end
      end
    end
  end
endmodule

// File: tb/tb_rpmp_host_link.sv
// Directed bench for rpmp_host_link with a cartridge model that echoes ratn on ack.
module tb_rpmp_host_link;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        atn = 1'b1;
  logic        ack;
  logic        ratn;
  logic [1:0]  cmd;
  logic [15:0] r_o;
  logic [1:0]  r_oe;
  logic [15:0] r_i;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [15:0] req_data = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        evt_valid;
  logic [15:0] evt_status;
  logic        err;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  // Cartridge model: ack follows ratn three clocks later; r_i valid only while strobed.
  logic [2:0]  ack_pipe = 3'b000;
  logic        ack_en = 1'b1;
  logic [15:0] cart_data = 16'h0000;
  always @(posedge clk) ack_pipe <= {ack_pipe[1:0], ratn};
  assign ack = ack_en & ack_pipe[2];
  assign r_i = ratn ? cart_data : 16'h0000;

  always #5 clk = ~clk;

  rpmp_host_link #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2), .ACK_TIMEOUT(200)) dut (
    .clk(clk), .reset(reset), .atn(atn), .ack(ack), .ratn(ratn), .cmd(cmd), .r_o(r_o),
    .r_oe(r_oe), .r_i(r_i), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .evt_valid(evt_valid),
    .evt_status(evt_status), .err(err), .busy(busy)
  );

  // Observations collected over a window of cycles
  int          obs_rsp, obs_evt, obs_err, obs_err_cyc, obs_nstb;
  logic [15:0] obs_rsp_data, obs_evt_status;
  logic [1:0]  stb_cmd [4];
  logic [1:0]  stb_oe  [4];
  logic [15:0] stb_ro  [4];
  logic        obs_ratn_end;

  task automatic observe(input int ncyc);
    logic prev = 1'b0;
    obs_rsp = 0; obs_evt = 0; obs_err = 0; obs_err_cyc = -1; obs_nstb = 0;
    obs_rsp_data = 16'hxxxx; obs_evt_status = 16'hxxxx;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (rsp_valid) begin obs_rsp++; obs_rsp_data = rsp_data; end
      if (evt_valid) begin obs_evt++; obs_evt_status = evt_status; end
      if (err) begin obs_err++; if (obs_err_cyc < 0) obs_err_cyc = i; end
      if (ratn && !prev && obs_nstb < 4) begin
        stb_cmd[obs_nstb] = cmd; stb_oe[obs_nstb] = r_oe; stb_ro[obs_nstb] = r_o;
        obs_nstb++;
      end
      prev = ratn;
    end
    obs_ratn_end = ratn;
  endtask

  // Presents a request and returns once it is accepted (or the bound expires).
  task automatic issue(input logic [1:0] op, input logic [15:0] data, output bit ok);
    req_op = op; req_data = data; req_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_chk++; if (ratn !== 1'b0 || cmd !== 2'b00 || r_o !== 16'h0 || r_oe !== 2'b00) begin
      n_fail++; $display("FAIL reset_bus: ratn=%b cmd=%b r_o=%h r_oe=%b want 0/00/0000/00", ratn, cmd, r_o, r_oe); end
    n_chk++; if (rsp_valid !== 1'b0 || evt_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: rsp=%b evt=%b err=%b busy=%b want 0", rsp_valid, evt_valid, err, busy); end
    n_chk++; if (rsp_data !== 16'h0 || evt_status !== 16'h0) begin
      n_fail++; $display("FAIL reset_data: rsp_data=%h evt_status=%h want 0000", rsp_data, evt_status); end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    n_chk++; if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: req_ready=%b want 1", req_ready); end
  endtask

  task automatic test_ctrl_write;
    bit ok;
    issue(2'b11, 16'hA055, ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL ctrl_accept: not accepted, want accepted"); end
    observe(60);
    n_chk++; if (obs_nstb !== 1 || stb_cmd[0] !== 2'b11 || stb_oe[0] !== 2'b11 || stb_ro[0] !== 16'hA055) begin
      n_fail++; $display("FAIL ctrl_drive: strobes=%0d cmd=%b oe=%b r_o=%h want 1/11/11/a055",
                         obs_nstb, stb_cmd[0], stb_oe[0], stb_ro[0]); end
    n_chk++; if (obs_rsp !== 1 || obs_rsp_data !== 16'h0000 || obs_err !== 0 || obs_evt !== 0) begin
      n_fail++; $display("FAIL ctrl_rsp: rsp=%0d data=%h err=%0d evt=%0d want 1/0000/0/0",
                         obs_rsp, obs_rsp_data, obs_err, obs_evt); end
    n_chk++; if (r_oe !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ctrl_idle: r_oe=%b busy=%b want 00/0", r_oe, busy); end
  endtask

  task automatic test_status_read;
    bit ok;
    cart_data = 16'h8023;
    issue(2'b01, 16'hFFFF, ok);
    observe(60);
    n_chk++; if (!ok || obs_rsp !== 1 || obs_rsp_data !== 16'h8023) begin
      n_fail++; $display("FAIL status_read: ok=%b rsp=%0d data=%h want 1/1/8023", ok, obs_rsp, obs_rsp_data); end
    n_chk++; if (stb_cmd[0] !== 2'b01 || stb_oe[0] !== 2'b00) begin
      n_fail++; $display("FAIL status_drive: cmd=%b oe=%b want 01/00", stb_cmd[0], stb_oe[0]); end
    cart_data = 16'h1357;
    issue(2'b00, 16'h0000, ok);
    observe(60);
    n_chk++; if (!ok || obs_rsp !== 1 || obs_rsp_data !== 16'h1357 || stb_cmd[0] !== 2'b00) begin
      n_fail++; $display("FAIL test_read: ok=%b rsp=%0d data=%h cmd=%b want 1/1/1357/00",
                         ok, obs_rsp, obs_rsp_data, stb_cmd[0]); end
  endtask

  task automatic test_event;
    cart_data = 16'h40C3;
    atn = 1'b0;
    observe(60);
    n_chk++; if (obs_evt !== 1 || obs_evt_status !== 16'h40C3) begin
      n_fail++; $display("FAIL evt_fetch: evt=%0d status=%h want 1/40c3", obs_evt, obs_evt_status); end
    n_chk++; if (obs_rsp !== 0 || obs_nstb !== 1 || stb_cmd[0] !== 2'b01 || stb_oe[0] !== 2'b00) begin
      n_fail++; $display("FAIL evt_only: rsp=%0d strobes=%0d cmd=%b oe=%b want 0/1/01/00",
                         obs_rsp, obs_nstb, stb_cmd[0], stb_oe[0]); end
    atn = 1'b1;
    observe(20);
    n_chk++; if (obs_evt !== 0 || obs_nstb !== 0) begin
      n_fail++; $display("FAIL evt_rise: evt=%0d strobes=%0d want 0/0", obs_evt, obs_nstb); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    logic rdy_seen;
    cart_data = 16'h9001;
    atn = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    // The synchronised atn edge now lines up with the request below.
    fork
      issue(2'b10, 16'h005A, ok);
      observe(120);
      begin @(negedge clk); rdy_seen = req_ready; end
    join
    n_chk++; if (rdy_seen !== 1'b0) begin
      n_fail++; $display("FAIL b2b_ready: req_ready=%b want 0", rdy_seen); end
    n_chk++; if (!ok || obs_nstb !== 2 || stb_cmd[0] !== 2'b01 || stb_cmd[1] !== 2'b10) begin
      n_fail++; $display("FAIL b2b_order: ok=%b strobes=%0d cmd0=%b cmd1=%b want 1/2/01/10",
                         ok, obs_nstb, stb_cmd[0], stb_cmd[1]); end
    n_chk++; if (stb_oe[1] !== 2'b01 || stb_ro[1] !== 16'h005A) begin
      n_fail++; $display("FAIL b2b_drive: oe=%b r_o=%h want 01/005a", stb_oe[1], stb_ro[1]); end
    n_chk++; if (obs_evt !== 1 || obs_evt_status !== 16'h9001 || obs_rsp !== 1 || obs_rsp_data !== 16'h0000) begin
      n_fail++; $display("FAIL b2b_done: evt=%0d st=%h rsp=%0d data=%h want 1/9001/1/0000",
                         obs_evt, obs_evt_status, obs_rsp, obs_rsp_data); end
    atn = 1'b1;
    repeat (5) @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    bit ok;
    ack_en = 1'b0;
    issue(2'b11, 16'h1234, ok);
    observe(260);
    n_chk++; if (obs_err !== 1 || obs_rsp !== 0 || obs_evt !== 0) begin
      n_fail++; $display("FAIL tmo_pulse: err=%0d rsp=%0d evt=%0d want 1/0/0", obs_err, obs_rsp, obs_evt); end
    n_chk++; if (obs_err_cyc < 200 || obs_err_cyc > 210) begin
      n_fail++; $display("FAIL tmo_time: err at cycle %0d want 200..210", obs_err_cyc); end
    n_chk++; if (obs_ratn_end !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL tmo_idle: ratn=%b busy=%b want 0/0", obs_ratn_end, busy); end
    ack_en = 1'b1;
    cart_data = 16'h0BEE;
    issue(2'b01, 16'h0000, ok);
    observe(60);
    n_chk++; if (!ok || obs_rsp !== 1 || obs_rsp_data !== 16'h0BEE || obs_err !== 0) begin
      n_fail++; $display("FAIL tmo_recover: ok=%b rsp=%0d data=%h err=%0d want 1/1/0bee/0",
                         ok, obs_rsp, obs_rsp_data, obs_err); end
  endtask

  task automatic test_reset_mid;
    bit ok, seen;
    cart_data = 16'h7777;
    issue(2'b11, 16'hC3C3, ok);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk); if (ratn) seen = 1'b1; end
    n_chk++; if (!ok || !seen) begin
      n_fail++; $display("FAIL mid_start: ok=%b ratn_seen=%b want 1/1", ok, seen); end
    // ratn rises entering the ack wait; seven clocks later the strobe phase is in progress
    repeat (7) @(negedge clk);
    reset = 1'b1;
    #1;
    n_chk++; if (ratn !== 1'b0 || r_oe !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_abort: ratn=%b r_oe=%b busy=%b want 0/00/0", ratn, r_oe, busy); end
    repeat (2) @(posedge clk); #1 reset = 1'b0;
    observe(40);
    n_chk++; if (obs_rsp !== 0 || obs_evt !== 0 || obs_err !== 0 || obs_nstb !== 0) begin
      n_fail++; $display("FAIL mid_quiet: rsp=%0d evt=%0d err=%0d strobes=%0d want 0/0/0/0",
                         obs_rsp, obs_evt, obs_err, obs_nstb); end
  endtask

  initial begin
    test_reset;
    test_ctrl_write;
    test_status_read;
    test_event;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
